// File: rtl/soc_event_fifo_mc_if.sv
// Peripheral-bus port of soc_event_fifo_mc: request/grant plus a one-cycle
// registered response. The bus master drives the request side.
interface soc_event_fifo_mc_if;
    logic        req_i;
    logic [31:0] add_i;
    logic        wen_i;
    logic [31:0] wdata_i;
    logic        gnt_o;
    logic        r_valid_o;
    logic [31:0] r_rdata_o;

    modport master (output req_i, add_i, wen_i, wdata_i, input gnt_o, r_valid_o, r_rdata_o);
    modport slave  (input req_i, add_i, wen_i, wdata_i, output gnt_o, r_valid_o, r_rdata_o);
endinterface

// File: rtl/soc_event_fifo_mc.sv
// Multi-channel event FIFO: round-robin producer arbiter, register-mapped pop/peek/status/threshold.
// Define SOC_EVENT_FIFO_CHAN_TAG_EN to store and return the source channel index with each entry.
module soc_event_fifo_mc #(
    parameter int unsigned NUM_CHAN   = 4,
    parameter int unsigned ID_WIDTH   = 8,
    parameter int unsigned FIFO_DEPTH = 6
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_CHAN-1:0]          chan_valid_i,
    output logic [NUM_CHAN-1:0]          chan_ready_o,
    input  logic [NUM_CHAN*ID_WIDTH-1:0] chan_data_i,
    soc_event_fifo_mc_if.slave           bus,
    output logic                         incoming_evt_o,
    output logic                         irq_o
);
    localparam int unsigned CH_W  = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1;
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [ID_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [ID_WIDTH-1:0] mem_d [FIFO_DEPTH];
`ifdef SOC_EVENT_FIFO_CHAN_TAG_EN
    logic [CH_W-1:0]     tag_q [FIFO_DEPTH];
    logic [CH_W-1:0]     tag_d [FIFO_DEPTH];
`endif
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [CH_W-1:0]     rr_q, rr_d;
    logic                ovf_q, ovf_d;
    logic [15:0]         thr_q, thr_d;
    logic                r_valid_q, r_valid_d;
    logic [31:0]         r_rdata_q, r_rdata_d;

    logic                full, empty, grant_found, push, pop, rd_req, wr_req;
    logic [CH_W-1:0]     grant_idx, chan_c;
    logic [ID_WIDTH-1:0] push_id;
    logic [1:0]          sel;
    logic [31:0]         head_word, status_word;
    logic                unused_bits;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty = (count_q == '0);

    // First requesting channel at or after the round-robin pointer.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        chan_c      = '0;
        for (int unsigned i = 0; i < NUM_CHAN; i++) begin
            chan_c = CH_W'((32'(rr_q) + i) % NUM_CHAN);
            if (!grant_found && chan_valid_i[chan_c]) begin
                grant_found = 1'b1;
                grant_idx   = chan_c;
            end
        end
    end

    assign push         = grant_found && !full;
    assign chan_ready_o = push ? (NUM_CHAN'(1) << grant_idx) : '0;
    assign push_id      = chan_data_i[32'(grant_idx)*ID_WIDTH +: ID_WIDTH];

    assign sel    = bus.add_i[3:2];
    assign rd_req = bus.req_i && bus.wen_i;
    assign wr_req = bus.req_i && !bus.wen_i;
    assign pop    = rd_req && (sel == 2'd0) && !empty;

    always_comb begin
        head_word                 = '0;
        head_word[ID_WIDTH-1:0]   = mem_q[rd_ptr_q];
`ifdef SOC_EVENT_FIFO_CHAN_TAG_EN
        if (NUM_CHAN > 1) head_word[ID_WIDTH +: CH_W] = tag_q[rd_ptr_q];
`endif
        head_word[31]             = !empty;
    end

    assign status_word = {14'd0, full, ovf_q, 16'(count_q)};

    always_comb begin
        r_valid_d = bus.req_i;
        r_rdata_d = '0;
        if (rd_req) begin
            case (sel)
                2'd0, 2'd1: r_rdata_d = head_word;
                2'd2:       r_rdata_d = status_word;
                default:    r_rdata_d = {16'd0, thr_q};
            endcase
        end
    end

    always_comb begin
        mem_d    = mem_q;
`ifdef SOC_EVENT_FIFO_CHAN_TAG_EN
        tag_d    = tag_q;
`endif
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        rr_d     = rr_q;
        if (push) begin
            mem_d[wr_ptr_q] = push_id;
`ifdef SOC_EVENT_FIFO_CHAN_TAG_EN
            tag_d[wr_ptr_q] = grant_idx;
`endif
            wr_ptr_d = ptr_inc(wr_ptr_q);
            rr_d     = (grant_idx == CH_W'(NUM_CHAN - 1)) ? '0 : grant_idx + CH_W'(1);
        end
        if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);

        // A set from a refused push outranks a software clear in the same cycle.
        ovf_d = ovf_q;
        if (wr_req && (sel == 2'd2) && bus.wdata_i[16]) ovf_d = 1'b0;
        if ((|chan_valid_i) && full) ovf_d = 1'b1;

        thr_d = thr_q;
        if (wr_req && (sel == 2'd3)) thr_d = bus.wdata_i[15:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem_q     <= '{default: '0};
`ifdef SOC_EVENT_FIFO_CHAN_TAG_EN
            tag_q     <= '{default: '0};
`endif
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            rr_q      <= '0;
            ovf_q     <= 1'b0;
            thr_q     <= 16'd1;
            r_valid_q <= 1'b0;
            r_rdata_q <= '0;
        end else begin
            mem_q     <= mem_d;
`ifdef SOC_EVENT_FIFO_CHAN_TAG_EN
            tag_q     <= tag_d;
`endif
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            rr_q      <= rr_d;
            ovf_q     <= ovf_d;
            thr_q     <= thr_d;
            r_valid_q <= r_valid_d;
            r_rdata_q <= r_rdata_d;
        end
    end

    assign bus.gnt_o      = bus.req_i;
    assign bus.r_valid_o  = r_valid_q;
    assign bus.r_rdata_o  = r_rdata_q;
    assign incoming_evt_o = !empty;
    assign irq_o          = (thr_q != 16'd0) && (16'(count_q) >= thr_q);

    assign unused_bits = ^{bus.add_i[31:4], bus.add_i[1:0], bus.wdata_i[31:17]};
endmodule

// File: tb/tb_soc_event_fifo_mc.sv
// Randomised self-checking bench for soc_event_fifo_mc against a queue-based reference model.
// Define SOC_EVENT_FIFO_CHAN_TAG_EN for both bench and RTL to exercise channel tags.
`timescale 1ns/1ps
module tb_soc_event_fifo_mc;
    localparam int unsigned N     = 4;
    localparam int unsigned IDW   = 8;
    localparam int unsigned DEPTH = 6;
    localparam logic [31:0] A_POP = 32'h0, A_PEEK = 32'h4, A_STAT = 32'h8, A_THR = 32'hC;
    localparam logic [N-1:0] RR_GNT [4] = '{4'b0001, 4'b0010, 4'b1000, 4'b0001};
`ifdef SOC_EVENT_FIFO_CHAN_TAG_EN
    localparam logic [31:0] RR_POP [3] = '{32'h8000_0010, 32'h8000_0111, 32'h8000_0313};
`else
    localparam logic [31:0] RR_POP [3] = '{32'h8000_0010, 32'h8000_0011, 32'h8000_0013};
`endif

    logic             clk = 1'b0;
    logic             rst_i;
    logic [N-1:0]     chan_valid_i, chan_ready_o;
    logic [IDW-1:0]   ch_data [N];
    logic [N*IDW-1:0] chan_data_i;
    logic             incoming_evt_o, irq_o;
    soc_event_fifo_mc_if bus_if ();

    always #5 clk = ~clk;

    always_comb begin
        chan_data_i = '0;
        for (int i = 0; i < N; i++) chan_data_i[i*IDW +: IDW] = ch_data[i];
    end

    soc_event_fifo_mc #(.NUM_CHAN(N), .ID_WIDTH(IDW), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .chan_valid_i   (chan_valid_i),
        .chan_ready_o   (chan_ready_o),
        .chan_data_i    (chan_data_i),
        .bus            (bus_if),
        .incoming_evt_o (incoming_evt_o),
        .irq_o          (irq_o)
    );

    // Reference model: FIFO contents as a queue of response words (tag/ID, valid bit clear).
    logic [31:0]  m_q [$];
    int unsigned  m_rr, m_g;
    bit           m_found, m_ovf;
    logic [15:0]  m_thr;
    logic         exp_rv;
    logic [31:0]  exp_rd, exp_rm;
    logic [N-1:0] exp_ready;
    int           checks = 0, errors = 0;

    task automatic bus_set(input logic req, input logic [31:0] addr, input logic wen, input logic [31:0] wd);
        bus_if.req_i = req; bus_if.add_i = addr; bus_if.wen_i = wen; bus_if.wdata_i = wd;
    endtask

    task automatic model_eval;
        @(negedge clk);
        m_found = 1'b0;
        m_g     = 0;
        for (int i = 0; i < N; i++) begin
            int unsigned c;
            c = (m_rr + i) % N;
            if (!m_found && chan_valid_i[c]) begin m_found = 1'b1; m_g = c; end
        end
        exp_ready = (m_found && m_q.size() < DEPTH) ? (N'(1) << m_g) : '0;
    endtask

    task automatic model_commit;
        logic        rv_n;
        logic [31:0] rd_n, rm_n, e;
        bit          full, is_wr;
        logic [1:0]  sel;
        full  = (m_q.size() == DEPTH);
        sel   = bus_if.add_i[3:2];
        is_wr = bus_if.req_i && !bus_if.wen_i;
        rv_n  = bus_if.req_i;
        rd_n  = '0;
        rm_n  = '1;
        if (bus_if.req_i && bus_if.wen_i) begin
            case (sel)
                2'd0, 2'd1: if (m_q.size() > 0) rd_n = m_q[0] | 32'h8000_0000;
                            else rm_n = 32'h8000_0000;
                2'd2:       rd_n = {14'd0, full, m_ovf, 16'(m_q.size())};
                default:    rd_n = {16'd0, m_thr};
            endcase
        end
        if ((|chan_valid_i) && full) m_ovf = 1'b1;
        else if (is_wr && sel == 2'd2 && bus_if.wdata_i[16]) m_ovf = 1'b0;
        if (is_wr && sel == 2'd3) m_thr = bus_if.wdata_i[15:0];
        if (bus_if.req_i && bus_if.wen_i && sel == 2'd0 && m_q.size() > 0) void'(m_q.pop_front());
        if (m_found && !full) begin
            e = 32'(ch_data[m_g]);
`ifdef SOC_EVENT_FIFO_CHAN_TAG_EN
            e[IDW +: 2] = 2'(m_g);
`endif
            m_q.push_back(e);
            m_rr = (m_g + 1) % N;
        end
        if (rst_i) begin
            m_q.delete(); m_rr = 0; m_ovf = 1'b0; m_thr = 16'd1;
            rv_n = 1'b0; rd_n = '0; rm_n = '1;
        end
        @(posedge clk); #1;
        exp_rv = rv_n; exp_rd = rd_n; exp_rm = rm_n;
    endtask

    task automatic do_reset;
        rst_i = 1'b1; chan_valid_i = '0; bus_set(1'b0, '0, 1'b0, '0);
        model_eval(); model_commit();
        rst_i = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        bus_set(1'b1, A_STAT, 1'b1, '0);
        model_eval();
        checks++; if (bus_if.r_valid_o !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b exp 0", bus_if.r_valid_o); end
        checks++; if (incoming_evt_o !== 1'b0) begin errors++; $display("FAIL reset_evt got %b exp 0", incoming_evt_o); end
        checks++; if (irq_o !== 1'b0) begin errors++; $display("FAIL reset_irq got %b exp 0", irq_o); end
        model_commit();
        bus_set(1'b1, A_THR, 1'b1, '0);
        model_eval();
        checks++; if (bus_if.r_valid_o !== 1'b1 || bus_if.r_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_status got %b/%h exp 1/00000000", bus_if.r_valid_o, bus_if.r_rdata_o); end
        model_commit();
        bus_set(1'b0, '0, 1'b0, '0);
        model_eval();
        checks++; if (bus_if.r_rdata_o !== 32'h1) begin errors++; $display("FAIL reset_thr got %h exp 00000001", bus_if.r_rdata_o); end
        model_commit();
    endtask

    task automatic test_round_robin;
        do_reset();
        ch_data[0] = 8'h10; ch_data[1] = 8'h11; ch_data[2] = 8'h12; ch_data[3] = 8'h13;
        chan_valid_i = 4'b1011;
        for (int k = 0; k < 4; k++) begin
            model_eval();
            checks++; if (chan_ready_o !== RR_GNT[k]) begin errors++; $display("FAIL rr_ready[%0d] got %b exp %b", k, chan_ready_o, RR_GNT[k]); end
            model_commit();
        end
        chan_valid_i = '0;
        for (int k = 0; k < 4; k++) begin
            bus_set(k < 3, A_POP, 1'b1, '0);
            model_eval();
            if (k > 0) begin
                checks++; if (bus_if.r_valid_o !== 1'b1 || bus_if.r_rdata_o !== RR_POP[k-1]) begin errors++; $display("FAIL rr_pop[%0d] got %b/%h exp 1/%h", k-1, bus_if.r_valid_o, bus_if.r_rdata_o, RR_POP[k-1]); end
            end
            model_commit();
        end
    endtask

    task automatic test_full_ovf;
        do_reset();
        chan_valid_i = 4'b0100;
        for (int k = 0; k < 13; k++) begin
            ch_data[2] = IDW'($urandom);
            if (k == 10) chan_valid_i = '0;
            case (k)
                7:  bus_set(1'b1, A_STAT, 1'b1, '0);
                8:  bus_set(1'b1, A_POP, 1'b1, '0);
                10: bus_set(1'b1, A_STAT, 1'b0, 32'h0001_0000);
                11: bus_set(1'b1, A_STAT, 1'b1, '0);
                default: bus_set(1'b0, '0, 1'b0, '0);
            endcase
            model_eval();
            checks++; if (chan_ready_o !== exp_ready) begin errors++; $display("FAIL full_ready[%0d] got %b exp %b", k, chan_ready_o, exp_ready); end
            checks++; if (bus_if.r_valid_o !== exp_rv || (bus_if.r_rdata_o & exp_rm) !== (exp_rd & exp_rm)) begin errors++; $display("FAIL full_rsp[%0d] got %b/%h exp %b/%h", k, bus_if.r_valid_o, bus_if.r_rdata_o, exp_rv, exp_rd); end
            if (k == 6 || k == 8) begin
                checks++; if (chan_ready_o !== 4'b0000) begin errors++; $display("FAIL full_refuse[%0d] got %b exp 0000", k, chan_ready_o); end
            end
            if (k == 8) begin
                checks++; if (bus_if.r_rdata_o !== 32'h0003_0006) begin errors++; $display("FAIL full_status got %h exp 00030006", bus_if.r_rdata_o); end
            end
            if (k == 9) begin
                checks++; if (chan_ready_o !== 4'b0100) begin errors++; $display("FAIL full_repush got %b exp 0100", chan_ready_o); end
            end
            if (k == 12) begin
                checks++; if (bus_if.r_rdata_o !== 32'h0002_0006) begin errors++; $display("FAIL ovf_clear got %h exp 00020006", bus_if.r_rdata_o); end
            end
            model_commit();
        end
    endtask

    task automatic test_empty;
        do_reset();
        for (int k = 0; k < 7; k++) begin
            chan_valid_i = (k == 2) ? 4'b0001 : 4'b0000;
            ch_data[0] = 8'h2A;
            case (k)
                0:    bus_set(1'b1, A_POP, 1'b1, '0);
                1, 5: bus_set(1'b1, A_STAT, 1'b1, '0);
                3, 4: bus_set(1'b1, A_PEEK, 1'b1, '0);
                default: bus_set(1'b0, '0, 1'b0, '0);
            endcase
            model_eval();
            checks++; if (bus_if.r_valid_o !== exp_rv || (bus_if.r_rdata_o & exp_rm) !== (exp_rd & exp_rm)) begin errors++; $display("FAIL empty_rsp[%0d] got %b/%h exp %b/%h", k, bus_if.r_valid_o, bus_if.r_rdata_o, exp_rv, exp_rd); end
            if (k == 1) begin
                checks++; if (bus_if.r_rdata_o[31] !== 1'b0) begin errors++; $display("FAIL empty_pop_valid got %b exp 0", bus_if.r_rdata_o[31]); end
            end
            if (k == 2) begin
                checks++; if (bus_if.r_rdata_o !== 32'h0) begin errors++; $display("FAIL empty_count got %h exp 00000000", bus_if.r_rdata_o); end
            end
            if (k == 4 || k == 5) begin
                checks++; if (bus_if.r_rdata_o !== 32'h8000_002A) begin errors++; $display("FAIL peek[%0d] got %h exp 8000002a", k, bus_if.r_rdata_o); end
            end
            if (k == 6) begin
                checks++; if (bus_if.r_rdata_o !== 32'h1) begin errors++; $display("FAIL peek_count got %h exp 00000001", bus_if.r_rdata_o); end
            end
            model_commit();
        end
    endtask

    task automatic test_threshold;
        do_reset();
        for (int k = 0; k < 13; k++) begin
            ch_data[1] = IDW'($urandom);
            chan_valid_i = ((k >= 1 && k <= 3) || k >= 6) ? 4'b0010 : 4'b0000;
            case (k)
                0: bus_set(1'b1, A_THR, 1'b0, 32'd3);
                4: bus_set(1'b1, A_POP, 1'b1, '0);
                5: bus_set(1'b1, A_THR, 1'b0, 32'd0);
                default: bus_set(1'b0, '0, 1'b0, '0);
            endcase
            model_eval();
            checks++; if (irq_o !== ((m_thr != 0) && (m_q.size() >= int'(m_thr)))) begin errors++; $display("FAIL thr_irq[%0d] got %b", k, irq_o); end
            if (k == 3 || k == 4 || k == 5 || k == 12) begin
                checks++; if (irq_o !== (k == 4)) begin errors++; $display("FAIL thr_edge[%0d] got %b exp %b", k, irq_o, (k == 4)); end
            end
            model_commit();
        end
    endtask

    task automatic test_back_to_back;
        int unsigned pulses = 0;
        do_reset();
        for (int k = 0; k < 25; k++) begin
            int unsigned c;
            c = $urandom_range(0, N-1);
            ch_data[c] = IDW'($urandom);
            chan_valid_i = (k < 22) ? (N'(1) << c) : '0;
            bus_set(k >= 2 && k < 24, A_POP, 1'b1, '0);
            model_eval();
            if (bus_if.r_valid_o === 1'b1) pulses++;
            checks++; if (bus_if.r_valid_o !== exp_rv || (bus_if.r_rdata_o & exp_rm) !== (exp_rd & exp_rm)) begin errors++; $display("FAIL wrap_rsp[%0d] got %b/%h exp %b/%h", k, bus_if.r_valid_o, bus_if.r_rdata_o, exp_rv, exp_rd); end
            model_commit();
        end
        checks++; if (pulses != 22) begin errors++; $display("FAIL wrap_pulses got %0d exp 22", pulses); end
    endtask

    task automatic test_random;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            logic [31:0] a, wd;
            logic [1:0]  s;
            s  = 2'($urandom_range(0, 3));
            a  = $urandom; a[3:2] = s;
            wd = (s == 2'd3) ? 32'($urandom_range(0, 7)) : $urandom;
            for (int c = 0; c < N; c++) ch_data[c] = IDW'($urandom);
            chan_valid_i = ($urandom_range(0, 2) == 0) ? '0 : N'($urandom);
            bus_set(1'($urandom), a, $urandom_range(0, 3) != 0, wd);
            model_eval();
            checks++; if (chan_ready_o !== exp_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", k, chan_ready_o, exp_ready); end
            checks++; if (bus_if.r_valid_o !== exp_rv || (bus_if.r_rdata_o & exp_rm) !== (exp_rd & exp_rm)) begin errors++; $display("FAIL rnd_rsp[%0d] got %b/%h exp %b/%h", k, bus_if.r_valid_o, bus_if.r_rdata_o, exp_rv, exp_rd); end
            checks++; if (incoming_evt_o !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_evt[%0d] got %b exp %b", k, incoming_evt_o, (m_q.size() != 0)); end
            checks++; if (irq_o !== ((m_thr != 0) && (m_q.size() >= int'(m_thr)))) begin errors++; $display("FAIL rnd_irq[%0d] got %b", k, irq_o); end
            checks++; if (bus_if.gnt_o !== bus_if.req_i) begin errors++; $display("FAIL rnd_gnt[%0d] got %b exp %b", k, bus_if.gnt_o, bus_if.req_i); end
            model_commit();
        end
    endtask

    task automatic test_reset_mid;
        do_reset();
        chan_valid_i = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            ch_data[0] = IDW'($urandom);
            model_eval(); model_commit();
        end
        chan_valid_i = '0;
        bus_set(1'b1, A_POP, 1'b1, '0);
        rst_i = 1'b1;
        model_eval(); model_commit();
        rst_i = 1'b0;
        bus_set(1'b1, A_STAT, 1'b1, '0);
        model_eval();
        checks++; if (bus_if.r_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rvalid got %b exp 0", bus_if.r_valid_o); end
        checks++; if (incoming_evt_o !== 1'b0) begin errors++; $display("FAIL mid_evt got %b exp 0", incoming_evt_o); end
        model_commit();
        bus_set(1'b1, A_THR, 1'b1, '0);
        model_eval();
        checks++; if (bus_if.r_valid_o !== 1'b1 || bus_if.r_rdata_o !== 32'h0) begin errors++; $display("FAIL mid_status got %b/%h exp 1/00000000", bus_if.r_valid_o, bus_if.r_rdata_o); end
        model_commit();
        bus_set(1'b0, '0, 1'b0, '0);
        model_eval();
        checks++; if (bus_if.r_rdata_o !== 32'h1) begin errors++; $display("FAIL mid_thr got %h exp 00000001", bus_if.r_rdata_o); end
        model_commit();
    endtask

    initial begin
        rst_i = 1'b1;
        chan_valid_i = '0;
        for (int c = 0; c < N; c++) ch_data[c] = '0;
        bus_set(1'b0, '0, 1'b0, '0);
        m_rr = 0; m_ovf = 1'b0; m_thr = 16'd1;
        exp_rv = 1'b0; exp_rd = '0; exp_rm = '1; exp_ready = '0;
        test_reset();
        test_round_robin();
        test_full_ovf();
        test_empty();
        test_threshold();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
